// File: rtl/irq_excp_ctrl.sv
// Exception/interrupt controller: latches irq lines and undefined-instruction traps,
// picks the lowest eligible irq, captures EPC/cause/vector and tracks kernel mode.
module irq_excp_ctrl #(
  parameter int                  NUM_IRQ        = 4,
  parameter int                  ADDR_W         = 32,
  parameter logic [NUM_IRQ-1:0]  EDGE_MASK      = '0,
  parameter logic [ADDR_W-1:0]   EXCP_VEC       = 32'h80000008,
  parameter logic [ADDR_W-1:0]   IRQ_VEC_BASE   = 32'h80000010,
  parameter int                  IRQ_VEC_STRIDE = 4,
  localparam int                 CW             = $clog2(NUM_IRQ + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               excp_in,
  input  logic               ins_valid,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               eret_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               irq_ack,
  input  logic [CW-1:0]      ack_id,
  output logic               take_o,
  output logic               ret_o,
  output logic [ADDR_W-1:0]  vec_o,
  output logic [ADDR_W-1:0]  epc_o,
  output logic [CW-1:0]      cause_o,
  output logic               kmode_o,
  output logic [NUM_IRQ-1:0] pending_o,
  output logic [NUM_IRQ-1:0] mask_o,
  output logic [1:0]         state_o
);

  // Handshake: take_o/ret_o are single-cycle strobes with no ready; the decoder
  // must act on them in the cycle they are high (redirect PC, write EPC).
  typedef enum logic [1:0] {USER = 2'd0, TAKE = 2'd1, KERN = 2'd2, RET = 2'd3} state_t;

  state_t             r_state;
  logic               r_take, r_ret, r_kmode;
  logic [ADDR_W-1:0]  r_vec, r_epc;
  logic [CW-1:0]      r_cause;
  logic [NUM_IRQ-1:0] r_irq_q, r_irq_d, r_pend_e, r_mask;

  logic [NUM_IRQ-1:0] w_pending, w_elig, w_ack_mask;
  logic [CW-1:0]      w_idx;
  logic               w_found;
  logic [ADDR_W-1:0]  w_irq_vec;

  assign w_pending = (r_irq_q & ~EDGE_MASK) | (r_pend_e & EDGE_MASK);
  assign w_elig    = w_pending & r_mask;
  assign w_irq_vec = IRQ_VEC_BASE + ADDR_W'(w_idx) * ADDR_W'(IRQ_VEC_STRIDE);

  // Lowest-numbered eligible channel wins.
  always_comb begin
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (w_elig[k] && !w_found) begin
        w_found = 1'b1;
        w_idx   = CW'(k);
      end
    end
  end

  always_comb begin
    w_ack_mask = '0;
    for (int k = 0; k < NUM_IRQ; k++)
      w_ack_mask[k] = irq_ack && (ack_id == CW'(k + 1));
  end

  // Edge pending: a fresh rising edge beats a same-cycle acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_q  <= '0;
      r_irq_d  <= '0;
      r_pend_e <= '0;
      r_mask   <= '0;
    end else begin
      r_irq_q  <= irq_in;
      r_irq_d  <= r_irq_q;
      r_pend_e <= ((r_irq_q & ~r_irq_d) | (r_pend_e & ~w_ack_mask)) & EDGE_MASK;
      if (mask_we) r_mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= KERN;
      r_kmode <= 1'b1;
      r_take  <= 1'b0;
      r_ret   <= 1'b0;
      r_vec   <= '0;
      r_epc   <= '0;
      r_cause <= '0;
    end else begin
      r_take <= 1'b0;
      r_ret  <= 1'b0;
      case (r_state)
        USER: begin
          if (ins_valid && (excp_in || w_found)) begin
            r_state <= TAKE;
            r_kmode <= 1'b1;
            r_take  <= 1'b1;
            r_epc   <= pc_in;
            if (excp_in) begin
              r_cause <= '0;
              r_vec   <= EXCP_VEC;
            end else begin
              r_cause <= w_idx + CW'(1);
              r_vec   <= w_irq_vec;
            end
          end
        end
        TAKE: r_state <= KERN;
        KERN: begin
          if (eret_in && ins_valid) begin
            r_state <= RET;
            r_ret   <= 1'b1;
          end
        end
        RET: begin
          r_state <= USER;
          r_kmode <= 1'b0;
        end
        default: r_state <= KERN;
      endcase
    end
  end

  assign take_o    = r_take;
  assign ret_o     = r_ret;
  assign vec_o     = r_vec;
  assign epc_o     = r_epc;
  assign cause_o   = r_cause;
  assign kmode_o   = r_kmode;
  assign pending_o = w_pending;
  assign mask_o    = r_mask;
  assign state_o   = r_state;

endmodule
